// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory-stage state encoding, timeout default
// and a word-alignment helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int TIMEOUT_CYC_DEFAULT = 255;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Counts memory wait cycles; expired marks the cycle that would make the
// MAX_CYC-th consecutive wait without an acknowledge.
module ack_timer
    import pipeline_pkg::*;
#(
    parameter int MAX_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] count;

    assign expired = enable && (count == CNT_W'(MAX_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one load/store at a time to data memory and
// produces a single-cycle writeback strobe, aborting on an ack timeout.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_in,
    input  logic              is_write_in,
    input  logic              is_store_in,
    input  logic              is_load_in,
    input  logic              is_branch,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              mem_err
);

    state_t      state;
    logic        op_load;
    logic [4:0]  op_rd;
    logic [31:0] op_alu;
    logic        take_load;
    logic        take_store;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;

    // Branches never touch memory; a load flag outranks a store flag.
    assign take_load  = is_load_in && !is_branch;
    assign take_store = is_store_in && !is_load_in && !is_branch;
    assign ready_out  = (state == IDLE);

    assign timer_clear  = (state != REQ);
    assign timer_enable = (state == REQ) && !mem_ack;

    ack_timer #(
        .MAX_CYC (TIMEOUT_CYC)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_load   <= 1'b0;
            op_rd     <= '0;
            op_alu    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            mem_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        op_load   <= take_load;
                        op_rd     <= rd_in;
                        op_alu    <= alu_result;
                        mem_we    <= take_store;
                        mem_addr  <= ADDR_W'(word_align(alu_result));
                        mem_wdata <= store_data;
                        if (take_load || take_store) begin
                            mem_req <= 1'b1;
                            state   <= REQ;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= is_write_in && !is_branch;
                            wb_rd    <= rd_in;
                            wb_data  <= alu_result;
                            state    <= WB;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the last allowed cycle still counts as success.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= op_load;
                        wb_rd    <= op_rd;
                        wb_data  <= op_load ? mem_rdata : op_alu;
                        state    <= WB;
                    end else if (timer_expired) begin
                        mem_req  <= 1'b0;
                        mem_err  <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_rd    <= op_rd;
                        wb_data  <= op_alu;
                        state    <= WB;
                    end
                end
                WB: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU, load, store, priority,
// timeout, ack-wins boundary, reset abort and backpressure.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        is_write_in;
    logic        is_store_in;
    logic        is_load_in;
    logic        is_branch;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(
        .TIMEOUT_CYC (255),
        .ADDR_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .rd_in       (rd_in),
        .is_write_in (is_write_in),
        .is_store_in (is_store_in),
        .is_load_in  (is_load_in),
        .is_branch   (is_branch),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                                 input logic [4:0] rd, input logic w, input logic s,
                                 input logic l, input logic b);
        valid_in    = v;
        alu_result  = alu;
        store_data  = sd;
        rd_in       = rd;
        is_write_in = w;
        is_store_in = s;
        is_load_in  = l;
        is_branch   = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mem_req and wb_valid must be mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (!rst) checkOutput("req_wb_excl", {31'b0, mem_req & wb_valid}, 32'd0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_ready", {31'b0, ready_out}, 32'd1);
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_mem_err", {31'b0, mem_err}, 32'd0);
        rst = 1'b0;
        tick();

        // ALU op: writeback one cycle after accept, no memory access
        applyStimulus(1, 32'h0000_0042, 32'd0, 5'd5, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("alu_wb_we", {31'b0, wb_we}, 32'd1);
        checkOutput("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
        checkOutput("alu_wb_data", wb_data, 32'h42);
        checkOutput("alu_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("alu_ready", {31'b0, ready_out}, 32'd0);
        tick();
        checkOutput("alu_wb_drop", {31'b0, wb_valid}, 32'd0);
        checkOutput("alu_ready_back", {31'b0, ready_out}, 32'd1);
        checkOutput("alu_no_req", {31'b0, mem_req}, 32'd0);

        // Ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("idle_ack_wb", {31'b0, wb_valid}, 32'd0);
        checkOutput("idle_ack_ready", {31'b0, ready_out}, 32'd1);

        // Load with ack three cycles after mem_req rises
        applyStimulus(1, 32'h0000_1003, 32'd0, 5'd7, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("ld_req", {31'b0, mem_req}, 32'd1);
        checkOutput("ld_we", {31'b0, mem_we}, 32'd0);
        checkOutput("ld_addr", mem_addr, 32'h1000);
        tick();
        tick();
        checkOutput("ld_req_hold", {31'b0, mem_req}, 32'd1);
        checkOutput("ld_addr_hold", mem_addr, 32'h1000);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        checkOutput("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("ld_wb_we", {31'b0, wb_we}, 32'd1);
        checkOutput("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        checkOutput("ld_wb_rd", {27'b0, wb_rd}, 32'd7);
        checkOutput("ld_req_drop", {31'b0, mem_req}, 32'd0);
        tick();
        checkOutput("ld_ready", {31'b0, ready_out}, 32'd1);

        // Store: write held until ack, no register write
        applyStimulus(1, 32'h0000_2000, 32'h0000_1234, 5'd3, 1, 1, 0, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("st_we", {31'b0, mem_we}, 32'd1);
        checkOutput("st_wdata", mem_wdata, 32'h1234);
        checkOutput("st_addr", mem_addr, 32'h2000);
        tick();
        checkOutput("st_req_hold", {31'b0, mem_req}, 32'd1);
        checkOutput("st_wdata_hold", mem_wdata, 32'h1234);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        checkOutput("st_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("st_wb_we", {31'b0, wb_we}, 32'd0);
        checkOutput("st_wb_data", wb_data, 32'h2000);
        tick();

        // Load flag outranks store flag
        applyStimulus(1, 32'h0000_3006, 32'h0000_9999, 5'd4, 0, 1, 1, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("prio_we", {31'b0, mem_we}, 32'd0);
        checkOutput("prio_addr", mem_addr, 32'h3004);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        checkOutput("prio_wb_we", {31'b0, wb_we}, 32'd1);
        checkOutput("prio_wb_data", wb_data, 32'h0BAD_F00D);
        tick();

        // Branch suppresses memory and writeback
        applyStimulus(1, 32'h0000_4000, 32'd0, 5'd9, 1, 0, 1, 1);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("br_req", {31'b0, mem_req}, 32'd0);
        checkOutput("br_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("br_wb_we", {31'b0, wb_we}, 32'd0);
        tick();

        // Timeout: mem_req held exactly 255 cycles, then aborted writeback
        applyStimulus(1, 32'h0000_5000, 32'd0, 5'd2, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        n = 0;
        while (mem_req && n < 300) begin
            n++;
            tick();
        end
        checkOutput("to_req_cycles", n, 32'd255);
        checkOutput("to_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("to_wb_we", {31'b0, wb_we}, 32'd0);
        checkOutput("to_mem_err", {31'b0, mem_err}, 32'd1);
        tick();
        applyStimulus(1, 32'h0000_0011, 32'd0, 5'd1, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        tick();
        checkOutput("to_err_sticky", {31'b0, mem_err}, 32'd1);

        // Reset clears the sticky error
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_clears_err", {31'b0, mem_err}, 32'd0);

        // Ack on the final allowed cycle wins over the timeout
        applyStimulus(1, 32'h0000_6000, 32'd0, 5'd6, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 254; i++) tick();
        checkOutput("aw_req_last", {31'b0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        checkOutput("aw_wb_we", {31'b0, wb_we}, 32'd1);
        checkOutput("aw_wb_data", wb_data, 32'hCAFE_F00D);
        checkOutput("aw_mem_err", {31'b0, mem_err}, 32'd0);
        tick();

        // Reset on the second REQ cycle aborts without writeback
        applyStimulus(1, 32'h0000_7000, 32'd0, 5'd8, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rr_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rr_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rr_ready", {31'b0, ready_out}, 32'd1);
        tick();
        checkOutput("rr_no_wb", {31'b0, wb_valid}, 32'd0);

        // Backpressure: valid_in stays high across a load
        applyStimulus(1, 32'h0000_8000, 32'd0, 5'd9, 0, 0, 1, 0);
        tick();
        applyStimulus(1, 32'h0000_0055, 32'd0, 5'd3, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("bp_ready_low", {31'b0, ready_out}, 32'd0);
            checkOutput("bp_no_wb", {31'b0, wb_valid}, 32'd0);
            tick();
        end
        checkOutput("bp_ready_low3", {31'b0, ready_out}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0077;
        tick();
        mem_ack = 1'b0;
        checkOutput("bp_wb_ready", {31'b0, ready_out}, 32'd0);
        checkOutput("bp_ld_wb_data", wb_data, 32'h77);
        checkOutput("bp_ld_wb_rd", {27'b0, wb_rd}, 32'd9);
        tick();
        checkOutput("bp_idle_ready", {31'b0, ready_out}, 32'd1);
        checkOutput("bp_idle_no_wb", {31'b0, wb_valid}, 32'd0);
        tick();
        applyStimulus(0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("bp_op2_wb", {31'b0, wb_valid}, 32'd1);
        checkOutput("bp_op2_data", wb_data, 32'h55);
        checkOutput("bp_op2_rd", {27'b0, wb_rd}, 32'd3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
